piso_shift_tx: RTL and testbench

- Parallel-in, serial-out bit transmitter. It is the launch side of a single-bit storage/capture path.
- Accepts a WIDTH-bit word through a valid/ready handshake. It drives the word out one bit at a time on sdo.
- Alongside sdo it drives a one-cycle bit_strobe that marks the sample point for a downstream capturing latch or flop.
- It sits between a word-level producer and a serial bit-capture receiver.

---
 rtl/piso_shift_tx_if.sv | 23 ++
 rtl/piso_shift_tx.sv | 126 ++++++++++++
 tb/tb_piso_shift_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_tx_if.sv
// Word-in / bit-out bundle for piso_shift_tx: producer handshake plus the serial
// launch signals seen by the downstream capture stage.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sdo;
    logic             bit_strobe;
    logic             frame;
    logic             done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, sdo, bit_strobe, frame, done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, sdo, bit_strobe, frame, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out bit launcher: one word per handshake, each bit held CLK_DIV cycles.
// Define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit period after the data bits.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    piso_shift_tx_if.slave  bus
);

`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = WIDTH + PAR;
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_n;
    logic [NBITS-1:0] shreg, sh_n, load_word, shifted;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [DW-1:0]    div_cnt, div_n;
    logic             sdo_q, sdo_n;
    logic             strobe_q, strobe_n;
    logic             frame_q, frame_n;
    logic             done_q, done_n;
    logic             last_div, last_bit;

    // Parity sits at the tail of the send order so it always goes out last.
    always_comb begin
`ifdef PISO_SHIFT_TX_PARITY_EN
        if (MSB_FIRST != 0) load_word = {bus.tx_data, ^bus.tx_data};
        else                load_word = {^bus.tx_data, bus.tx_data};
`else
        load_word = bus.tx_data;
`endif
    end

    assign shifted  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    assign last_div = (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == BW'(NBITS - 1));

    always_comb begin
        state_n  = state;
        sh_n     = shreg;
        bit_n    = bit_cnt;
        div_n    = div_cnt;
        sdo_n    = sdo_q;
        strobe_n = 1'b0;
        frame_n  = frame_q;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_n  = SHIFT;
                    sh_n     = load_word;
                    bit_n    = '0;
                    div_n    = '0;
                    sdo_n    = (MSB_FIRST != 0) ? load_word[NBITS-1] : load_word[0];
                    strobe_n = (CLK_DIV == 1);
                    frame_n  = 1'b1;
                end else begin
                    sdo_n   = 1'b0;
                    frame_n = 1'b0;
                end
            end
            SHIFT: begin
                if (last_div) begin
                    if (last_bit) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        div_n   = '0;
                        sdo_n   = 1'b0;
                        frame_n = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        sh_n     = shifted;
                        bit_n    = bit_cnt + 1'b1;
                        div_n    = '0;
                        sdo_n    = (MSB_FIRST != 0) ? shifted[NBITS-1] : shifted[0];
                        strobe_n = (CLK_DIV == 1);
                    end
                end else begin
                    // Outputs are registered, so the strobe is decided one cycle early.
                    div_n    = div_cnt + 1'b1;
                    strobe_n = (div_n == DW'(CLK_DIV - 1));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sdo_q    <= 1'b0;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= sh_n;
            bit_cnt  <= bit_n;
            div_cnt  <= div_n;
            sdo_q    <= sdo_n;
            strobe_q <= strobe_n;
            frame_q  <= frame_n;
            done_q   <= done_n;
        end
    end

    assign bus.tx_ready   = (state == IDLE);
    assign bus.sdo        = sdo_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.frame      = frame_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: u0 = MSB-first /4, u1 = LSB-first /1.
// Driver pushes expected bit sequences; one monitor pops them as frames appear.
module tb_piso_shift_tx;
    localparam int W = 8;
`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int CD0 = 4, CD1 = 1;
    localparam int LIM = 200, MAXC = 30000;

    typedef struct {
        logic [NB-1:0] seq;    // seq[i] = i-th bit on the wire
        int            start;  // cycle index of first frame cycle
        int            gap;    // required frame=0 cycles before, -1 = any
    } exp_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   n_chk, n_fail;
    bit   drv_done = 0, drv_to = 0;
    exp_t q0[$], q1[$];
    exp_t cur[2];
    bit   active[2];
    int   cnt[2], idle[2];

    piso_shift_tx_if #(.WIDTH(W)) i0 ();
    piso_shift_tx_if #(.WIDTH(W)) i1 ();

    piso_shift_tx #(.WIDTH(W), .CLK_DIV(CD0), .MSB_FIRST(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    piso_shift_tx #(.WIDTH(W), .CLK_DIV(CD1), .MSB_FIRST(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NB-1:0] mk_seq(input logic [W-1:0] d, input bit msb);
        logic [NB-1:0] s;
        int ones;
        s = '0;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            s[i] = msb ? d[W-1-i] : d[i];
            ones += int'(d[i]);
        end
        if (NB > W) s[NB-1] = ((ones % 2) == 1);
        return s;
    endfunction

    task automatic chk(input int g, input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", g, nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_step(input int g, input logic sdo, input logic stb,
                            input logic frm, input logic dn, input logic rdy);
        int cd;
        cd = (g == 0) ? CD0 : CD1;
        if (!rst_n) begin
            chk(g, "reset_outputs", {sdo, stb, frm, dn, rdy}, 5'b00001);
            active[g] = 0;
            idle[g]   = 0;
            return;
        end
        chk(g, "ready_vs_frame", rdy, !frm);
        if (frm) begin
            if (!active[g]) begin
                if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                    chk(g, "unexpected_frame", 1, 0);
                end else begin
                    cur[g]    = (g == 0) ? q0.pop_front() : q1.pop_front();
                    active[g] = 1;
                    cnt[g]    = 0;
                    chk(g, "frame_start", cyc, cur[g].start);
                    if (cur[g].gap >= 0) chk(g, "frame_gap", idle[g], cur[g].gap);
                end
            end
            if (active[g]) begin
                if (cnt[g] < NB * cd) chk(g, "sdo", sdo, cur[g].seq[cnt[g] / cd]);
                else                  chk(g, "frame_overrun", cnt[g], NB * cd - 1);
                chk(g, "bit_strobe", stb, (cnt[g] % cd) == cd - 1);
                chk(g, "done_in_frame", dn, 0);
                cnt[g]++;
            end
        end else begin
            chk(g, "idle_sdo_strobe", {sdo, stb}, 2'b00);
            if (active[g]) begin
                chk(g, "frame_len", cnt[g], NB * cd);
                chk(g, "done_pulse", dn, 1);
                active[g] = 0;
                idle[g]   = 1;
            end else begin
                chk(g, "no_done", dn, 0);
                idle[g]++;
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        active = '{0, 0};
        cnt    = '{0, 0};
        idle   = '{0, 0};
        for (int c = 0; c < MAXC && !drv_done; c++) begin
            @(negedge clk);
            mon_step(0, i0.sdo, i0.bit_strobe, i0.frame, i0.done, i0.tx_ready);
            mon_step(1, i1.sdo, i1.bit_strobe, i1.frame, i1.done, i1.tx_ready);
        end
        chk(0, "run_finished", drv_done, 1);
        chk(0, "driver_timeout", drv_to, 0);
        chk(0, "queue_drained", q0.size(), 0);
        chk(1, "queue_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------- driver ----------------
    task automatic drive(input int g, input logic v, input logic [W-1:0] d);
        if (g == 0) begin i0.tx_valid = v; i0.tx_data = d; end
        else        begin i1.tx_valid = v; i1.tx_data = d; end
    endtask

    function automatic logic rdy(input int g);
        return (g == 0) ? i0.tx_ready : i1.tx_ready;
    endfunction

    // Offer w; if hold, tx_valid stays high so the next call follows back-to-back.
    task automatic send(input int g, input logic [W-1:0] w, input int gap, input bit hold);
        exp_t e;
        int t;
        @(negedge clk);
        drive(g, 1'b1, w);
        t = 0;
        while (!rdy(g) && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (!rdy(g)) begin
            drv_to = 1;
            drive(g, 1'b0, w);
            return;
        end
        e.seq   = mk_seq(w, g == 0);
        e.start = cyc + 1;
        e.gap   = gap;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (!hold) begin
            @(negedge clk);
            drive(g, 1'b0, W'($urandom));
        end
    endtask

    task automatic rand_frames(input int g, input int n);
        bit prev_hold, hold;
        prev_hold = 0;
        for (int i = 0; i < n; i++) begin
            hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
            if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            send(g, W'($urandom), prev_hold ? 1 : -1, hold);
            prev_hold = hold;
        end
        repeat (NB * 4 + 6) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // u0: single frame, then abort a frame mid bit 3 with reset
        send(0, 8'hA5, -1, 0);
        repeat (NB * CD0 + 4) @(negedge clk);
        send(0, 8'h3C, -1, 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (NB * CD0 + 4) @(negedge clk);

        // busy ignore: data changes to FF mid-frame, taken on the done cycle
        send(0, 8'hA5, -1, 1);
        send(0, 8'hFF, 1, 0);
        repeat (NB * CD0 + 4) @(negedge clk);
        // continuous tx_valid across three words
        send(0, 8'h00, -1, 1);
        send(0, 8'hFF, 1, 1);
        send(0, 8'h3C, 1, 0);
        repeat (NB * CD0 + 4) @(negedge clk);
        rand_frames(0, 25);

        // u1: LSB-first, one cycle per bit
        send(1, 8'h01, -1, 0);
        repeat (NB + 4) @(negedge clk);
        send(1, 8'h00, -1, 1);
        send(1, 8'hFF, 1, 1);
        send(1, 8'h3C, 1, 0);
        repeat (NB + 4) @(negedge clk);
        rand_frames(1, 40);

        drv_done = 1;
    end

endmodule
